// File: rtl/dac_stream_controller.sv
// dac_stream_controller: paces AGC/test sample streams into a DAC at one sample per SAMPLE_DIV clocks.
// Ports: i_sys_clock/i_reset (async active-low) clock and reset; i_dac_init_done and i_iagc_status gate
// streaming; i_src_sel picks AGC (0) or test (1) source; *_valid/*_data_ch1/2 in, o_*_ready out form the
// per-source handshakes; o_data_ch1/2 + o_sample_strobe feed the DAC; o_underrun_count counts missed
// samples (cleared by i_clear_underrun); o_state exposes the FSM state.
module dac_stream_controller #(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int SAMPLE_DIV       = 4,
    parameter int MUTE_SAMPLES     = 8,
    parameter int UNDERRUN_SIZE    = 16
) (
    input  logic                        i_sys_clock,
    input  logic                        i_reset,
    input  logic                        i_dac_init_done,
    input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
    input  logic                        i_src_sel,
    input  logic                        i_agc_valid,
    input  logic [ZMOD_DATA_SIZE-1:0]   i_agc_data_ch1,
    input  logic [ZMOD_DATA_SIZE-1:0]   i_agc_data_ch2,
    output logic                        o_agc_ready,
    input  logic                        i_tst_valid,
    input  logic [ZMOD_DATA_SIZE-1:0]   i_tst_data_ch1,
    input  logic [ZMOD_DATA_SIZE-1:0]   i_tst_data_ch2,
    output logic                        o_tst_ready,
    input  logic                        i_clear_underrun,
    output logic [ZMOD_DATA_SIZE-1:0]   o_data_ch1,
    output logic [ZMOD_DATA_SIZE-1:0]   o_data_ch2,
    output logic                        o_sample_strobe,
    output logic [UNDERRUN_SIZE-1:0]    o_underrun_count,
    output logic [1:0]                  o_state
);
    typedef enum logic [1:0] {WAIT_INIT = 2'b00, MUTE = 2'b01, RUN = 2'b10} state_t;

    state_t                      state_q, state_d;
    logic [7:0]                  slot_q, slot_d;
    logic [7:0]                  mute_q, mute_d;
    logic                        active_src_q, active_src_d;
    logic                        src_sel_q;
    logic [ZMOD_DATA_SIZE-1:0]   data_ch1_q, data_ch1_d, data_ch2_q, data_ch2_d;
    logic                        strobe_q, strobe_d;
    logic [UNDERRUN_SIZE-1:0]    underrun_q, underrun_d;
    logic                        abort, slot_last, sel_valid, switch_req, run_slot;

    // Source requests are compared through a register so the readys depend on registered state only.
    assign abort      = !i_dac_init_done || (i_iagc_status == '0);
    assign slot_last  = slot_q == 8'(SAMPLE_DIV - 1);
    assign switch_req = src_sel_q != active_src_q;
    assign sel_valid  = active_src_q ? i_tst_valid : i_agc_valid;
    assign run_slot   = (state_q == RUN) && slot_last && !switch_req;

    assign o_agc_ready      = run_slot && !active_src_q;
    assign o_tst_ready      = run_slot && active_src_q;
    assign o_data_ch1       = data_ch1_q;
    assign o_data_ch2       = data_ch2_q;
    assign o_sample_strobe  = strobe_q;
    assign o_underrun_count = underrun_q;
    assign o_state          = state_q;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_last ? 8'd0 : slot_q + 8'd1;
        mute_d       = mute_q;
        active_src_d = active_src_q;
        data_ch1_d   = data_ch1_q;
        data_ch2_d   = data_ch2_q;
        strobe_d     = 1'b0;
        underrun_d   = underrun_q;
        if (abort) begin
            state_d    = WAIT_INIT;
            slot_d     = 8'd0;
            mute_d     = 8'd0;
            data_ch1_d = '0;
            data_ch2_d = '0;
        end else begin
            case (state_q)
                WAIT_INIT: begin
                    state_d      = MUTE;
                    slot_d       = 8'd0;
                    active_src_d = i_src_sel;
                    mute_d       = 8'(MUTE_SAMPLES);
                end
                MUTE: if (slot_last) begin
                    data_ch1_d = '0;
                    data_ch2_d = '0;
                    strobe_d   = 1'b1;
                    if (switch_req) begin
                        active_src_d = src_sel_q;
                        mute_d       = 8'(MUTE_SAMPLES);
                    end else begin
                        mute_d = mute_q - 8'd1;
                        if (mute_q == 8'd1) state_d = RUN;
                    end
                end
                RUN: if (slot_last) begin
                    // A source change takes the slot: no handshake, no strobe, straight into a fresh mute.
                    if (switch_req) begin
                        active_src_d = src_sel_q;
                        mute_d       = 8'(MUTE_SAMPLES);
                        state_d      = MUTE;
                    end else begin
                        strobe_d = 1'b1;
                        if (sel_valid) begin
                            data_ch1_d = active_src_q ? i_tst_data_ch1 : i_agc_data_ch1;
                            data_ch2_d = active_src_q ? i_tst_data_ch2 : i_agc_data_ch2;
                        end else if (underrun_q != '1) begin
                            underrun_d = underrun_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = WAIT_INIT;
                    slot_d  = 8'd0;
                end
            endcase
        end
        if (i_clear_underrun) underrun_d = '0;
    end

    always_ff @(posedge i_sys_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= WAIT_INIT;
            slot_q       <= 8'd0;
            mute_q       <= 8'd0;
            active_src_q <= 1'b0;
            src_sel_q    <= 1'b0;
            data_ch1_q   <= '0;
            data_ch2_q   <= '0;
            strobe_q     <= 1'b0;
            underrun_q   <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            mute_q       <= mute_d;
            active_src_q <= active_src_d;
            src_sel_q    <= i_src_sel;
            data_ch1_q   <= data_ch1_d;
            data_ch2_q   <= data_ch2_d;
            strobe_q     <= strobe_d;
            underrun_q   <= underrun_d;
        end
    end
endmodule

// File: doc/dac_stream_controller.md
DAC_STREAM_CONTROLLER -- requirements
Module: dac_stream_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: i_sys_clock, i_reset.
REQ-002 Parameters (name, default, meaning) SHALL be:
- ZMOD_DATA_SIZE, 14, sample width (two's complement).
- IAGC_STATUS_SIZE, 4, IAGC status width.
- SAMPLE_DIV, 4, clocks per sample slot (legal range 2..255).
- MUTE_SAMPLES, 8, zero samples emitted on start or source switch (legal range 1..255).
- UNDERRUN_SIZE, 16, underrun counter width.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- i_sys_clock, in, 1, system clock.
- i_reset, in, 1, asynchronous active-low reset.
- i_dac_init_done, in, 1, DAC controller initialised (active high).
- i_iagc_status, in, IAGC_STATUS_SIZE, IAGC status; 4'b0000 means IAGC in reset.
- i_src_sel, in, 1, requested source: 0 = AGC, 1 = test.
- i_agc_valid, in, 1, AGC sample valid.
- i_agc_data_ch1, in, ZMOD_DATA_SIZE, AGC channel-1 sample.
- i_agc_data_ch2, in, ZMOD_DATA_SIZE, AGC channel-2 sample.
- o_agc_ready, out, 1, AGC sample taken.
- i_tst_valid, in, 1, test sample valid.
- i_tst_data_ch1, in, ZMOD_DATA_SIZE, test channel-1 sample.
- i_tst_data_ch2, in, ZMOD_DATA_SIZE, test channel-2 sample.
- o_tst_ready, out, 1, test sample taken.
- i_clear_underrun, in, 1, synchronous clear of the underrun counter.
- o_data_ch1, out, ZMOD_DATA_SIZE, channel-1 data to the DAC controller.
- o_data_ch2, out, ZMOD_DATA_SIZE, channel-2 data to the DAC controller.
- o_sample_strobe, out, 1, one-cycle pulse when the outputs update.
- o_underrun_count, out, UNDERRUN_SIZE, count of missed samples.
- o_state, out, 2, current state: 00 WAIT_INIT, 01 MUTE, 10 RUN.

Function
REQ-004 The FSM SHALL have exactly three states: WAIT_INIT, MUTE and RUN; encoding 2'b11 SHALL be unreachable and SHALL recover to WAIT_INIT.
REQ-005 A slot counter SHALL count 0..SAMPLE_DIV-1 and wrap. A slot cycle is a cycle where the counter equals SAMPLE_DIV-1. The counter SHALL be held at 0 in WAIT_INIT.
REQ-006 The abort condition is: i_dac_init_done==0, or i_iagc_status==0. From any state, the abort condition SHALL force WAIT_INIT on the next cycle, with outputs driven to 0.
REQ-007 WAIT_INIT SHALL move to MUTE when the abort condition is false. On that transition, active_src SHALL be loaded with i_src_sel and the mute counter SHALL be loaded with MUTE_SAMPLES.
REQ-008 MUTE SHALL behave as follows at each slot cycle:
- Set o_data_ch1/ch2 to 0 and pulse o_sample_strobe.
- Decrement the mute counter.
- Move to RUN after the MUTE_SAMPLES-th zero sample.
REQ-009 In MUTE, if i_src_sel differs from active_src at a slot cycle, active_src SHALL update and the mute counter SHALL reload to MUTE_SAMPLES.
REQ-010 In RUN, at a slot cycle where i_src_sel differs from active_src, the block SHALL:
- Load active_src.
- Assert neither ready.
- Enter MUTE with the mute counter equal to MUTE_SAMPLES.
REQ-011 Ready generation in RUN: o_agc_ready (when active_src==0) or o_tst_ready (when active_src==1) SHALL be high for exactly the slot cycle. The non-selected ready SHALL stay 0. Both readys SHALL be 0 outside RUN. The non-selected valid SHALL be ignored.
REQ-012 A sample is accepted when valid and ready are both high in the same cycle. The accepted data SHALL appear on o_data_ch1/ch2, with o_sample_strobe=1, on the next cycle (latency 1).
REQ-013 In RUN, at a slot cycle where the selected valid is 0:
- o_data_ch1/ch2 SHALL hold their previous values.
- o_sample_strobe SHALL still pulse on the next cycle.
- o_underrun_count SHALL increment, saturating at all-ones.
REQ-014 i_clear_underrun SHALL zero the counter on the next cycle and SHALL win over a simultaneous increment. The counter SHALL be retained through WAIT_INIT.
REQ-015 o_sample_strobe SHALL be high only on the cycle after a slot cycle in MUTE or RUN. It SHALL be 0 in WAIT_INIT.
REQ-016 All outputs SHALL be registered, except o_agc_ready and o_tst_ready, which are decoded from registered state only.

Reset
REQ-017 While i_reset==0, the block SHALL hold the following values:
- State: WAIT_INIT.
- o_data_ch1/ch2: 0.
- o_sample_strobe, o_agc_ready, o_tst_ready: 0.
- o_underrun_count: 0.
- o_state: 2'b00.
- active_src: 0.
- Slot and mute counters: 0.
REQ-018 An asynchronous reset assertion mid-sample SHALL discard any in-flight sample. After deassertion, the block SHALL behave as on initial startup.

Verification
REQ-019 Startup: with status=4'b0001, raise init_done at cycle 10 with SAMPLE_DIV=4 and MUTE_SAMPLES=8 -> expected response:
- Exactly 8 zero strobes, 4 cycles apart.
- Then RUN (o_state=10).
- An AGC sample 14'h1ABC appears 1 cycle after the first ready.
REQ-020 Underrun: hold i_agc_valid=0 for 5 slots in RUN -> expected response:
- 5 strobes with held data.
- o_underrun_count=5.
- Asserting i_clear_underrun on the same cycle as a 6th underrun gives count 0.
REQ-021 Switch: flip i_src_sel 0->1 mid-slot in RUN -> expected response:
- No ready until the next slot.
- 8 zero samples, then o_tst_ready pulses and test data appears.
- i_agc_valid=1 throughout is ignored.
REQ-022 Abort: drive status=4'b0000 during MUTE, and separately drop init_done during RUN -> expected response:
- WAIT_INIT on the next cycle, with outputs 0 and no strobes.
- Restoring the inputs repeats the full 8-sample mute.
REQ-023 Saturation with UNDERRUN_SIZE=4: 20 underruns -> o_underrun_count=4'hF, with no wrap.
REQ-024 Reset mid-RUN: pulse i_reset low between the ready and the data update -> all outputs read 0 immediately, and the accepted sample never appears.
